// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//   Owns the single write port of registerFile and shares it between the
//   in-order writeback (fixed priority, never back-pressured) and the
//   long-latency unit (valid/ready). Keeps a busy scoreboard of registers
//   whose LLU result is still in flight and raises Stall to decode on
//   RAW/WAW hazards, a full LLU queue, or a starved LLU write.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   WbEnable/WbAdr/WbData        pipeline writeback request
//   LluValid/LluAdr/LluData      LLU result; LluReady grants the port
//   IssueLlu/IssueAdr            decode issuing an LLU op
//   rs1Adr/rs2Adr                decode sources
//   DecodeWrites/DecodeRd        decode destination (any unit)
//   Stall                        freeze fetch/decode
//   LluFull                      outstanding LLU ops == MAX_OUTSTANDING
//   WriteEnable/rd1Adr/Rd1       registerFile write port
module regfile_write_scheduler #(
  parameter int BIT_COUNT       = 32,
  parameter int REGISTER_COUNT  = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8,
  localparam int RSW            = $clog2(REGISTER_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WbEnable,
  input  logic [RSW-1:0]       WbAdr,
  input  logic [BIT_COUNT-1:0] WbData,
  input  logic                 LluValid,
  input  logic [RSW-1:0]       LluAdr,
  input  logic [BIT_COUNT-1:0] LluData,
  output logic                 LluReady,
  input  logic                 IssueLlu,
  input  logic [RSW-1:0]       IssueAdr,
  input  logic [RSW-1:0]       rs1Adr,
  input  logic [RSW-1:0]       rs2Adr,
  input  logic                 DecodeWrites,
  input  logic [RSW-1:0]       DecodeRd,
  output logic                 Stall,
  output logic                 LluFull,
  output logic                 WriteEnable,
  output logic [RSW-1:0]       rd1Adr,
  output logic [BIT_COUNT-1:0] Rd1
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [REGISTER_COUNT-1:0] r_busy;
  logic [CW-1:0]             r_count;
  logic [SW-1:0]             r_starve;

  logic                      w_grant;
  logic                      w_issue_acc;
  logic                      w_full;
  logic                      w_starve_stall;
  logic                      w_hazard;
  logic [REGISTER_COUNT-1:0] w_busy_nxt;

  // Arbitration: WB always wins; LLU only gets the port on idle WB cycles.
  assign LluReady = !reset && !WbEnable;
  assign w_grant  = LluValid && LluReady;

  always_comb begin
    WriteEnable = 1'b0;
    rd1Adr      = '0;
    Rd1         = '0;
    if (!reset) begin
      if (WbEnable) begin
        rd1Adr = WbAdr;
        Rd1    = WbData;
      end else if (w_grant) begin
        rd1Adr = LluAdr;
        Rd1    = LluData;
      end
      // Writes to x0 are dropped but an LLU grant still completes its handshake.
      WriteEnable = (WbEnable || w_grant) && (rd1Adr != '0);
    end
  end

  // Hazards come from registered state; a grant landing this cycle does not
  // unblock decode until busy clears at the edge.
  assign w_full         = (r_count == MAX_CNT);
  assign w_starve_stall = (r_starve >= STARVE_MAX);
  assign w_hazard = ((rs1Adr != '0) && r_busy[rs1Adr])
                 || ((rs2Adr != '0) && r_busy[rs2Adr])
                 || (DecodeWrites && (DecodeRd != '0) && r_busy[DecodeRd])
                 || (IssueLlu && w_full)
                 || w_starve_stall;

  assign Stall       = !reset && w_hazard;
  assign LluFull     = !reset && w_full;
  assign w_issue_acc = IssueLlu && !Stall;

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_grant) w_busy_nxt[LluAdr] = 1'b0;
    if (w_issue_acc && (IssueAdr != '0)) w_busy_nxt[IssueAdr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      r_busy <= w_busy_nxt;

      // Issue is blocked while full, so the increment cannot overflow.
      if (w_issue_acc && !w_grant)
        r_count <= r_count + CW'(1);
      else if (w_grant && !w_issue_acc && (r_count != '0))
        r_count <= r_count - CW'(1);

      if (!LluValid || w_grant)
        r_starve <= '0;
      else if (r_starve != STARVE_MAX)
        r_starve <= r_starve + SW'(1);
    end
  end

  // An LLU result with nothing outstanding means the LLU and decode disagree.
  a_grant_underflow: assert property (@(posedge clk) disable iff (reset)
    !(w_grant && (r_count == '0)));

endmodule
